// File: rtl/scroll_shift_register.sv
// scroll_shift_register
//   Loadable WIDTH-bit scroll engine with a built-in rate divider. A load
//   pulse captures a pattern and a mode and starts a run. The pattern then
//   steps once every DIV_COUNT clocks. Shift modes finish on their own after
//   WIDTH steps and pulse done. Rotate modes run until stop, load or reset.
//
// Ports
//   clock      in          system clock, posedge
//   reset      in          synchronous, active-high, highest priority
//   load       in          pulse: capture data_in/mode, (re)start run
//   data_in    in  WIDTH   pattern to load
//   mode       in  2       00 shl, 01 shr (zero fill), 10 rol, 11 ror
//   pause      in          level: freeze divider and pattern while running
//   stop       in          pulse: abort run, keep current pattern
//   q          out WIDTH   current pattern
//   serial_out out         msb for left modes, lsb for right modes
//   busy       out         high while running
//   done       out         one-cycle pulse when a shift run completes
module scroll_shift_register #(
  parameter int WIDTH     = 12,
  parameter int DIV_COUNT = 1000000,
  parameter int DIV_W     = 27
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       mode,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] pat_step;
  logic [1:0]       mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Per-bit step source. mode_q[0] selects the direction (1 = right) and
  // mode_q[1] selects rotate, which feeds the bit falling off one end back
  // into the other end instead of a zero.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic from_lo, from_hi;
    if (i == 0) begin : g_lo_edge
      assign from_lo = mode_q[1] & pat_q[WIDTH-1];
    end else begin : g_lo_mid
      assign from_lo = pat_q[i-1];
    end
    if (i == WIDTH-1) begin : g_hi_edge
      assign from_hi = mode_q[1] & pat_q[0];
    end else begin : g_hi_mid
      assign from_hi = pat_q[i+1];
    end
    assign pat_step[i] = mode_q[0] ? from_hi : from_lo;
  end

  // Priority below reset: load > stop > step. Stop therefore beats a step
  // that would have landed on the same edge.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    mode_d  = mode_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (load) begin
      pat_d   = data_in;
      mode_d  = mode;
      div_d   = '0;
      cnt_d   = '0;
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      if (stop) begin
        state_d = S_IDLE;
      end else if (!pause) begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          pat_d = pat_step;
          // Counter wraps after WIDTH steps; only shift modes act on it.
          cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
          if (!mode_q[1] && cnt_q == CNT_LAST) begin
            // WIDTH zero-fill shifts leave the pattern empty.
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
    end
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      mode_q  <= 2'b00;
      div_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q          = pat_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign serial_out = mode_q[0] ? pat_q[0] : pat_q[WIDTH-1];

endmodule

// File: tb/tb_scroll_shift_register.sv
module tb_scroll_shift_register;

  logic       clock = 1'b0;
  logic       reset, load, pause, stop;
  logic [7:0] data_in;
  logic [1:0] mode;
  logic [7:0] q4, q1;
  logic       so4, so1, busy4, busy1, done4, done1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  scroll_shift_register #(.WIDTH(8), .DIV_COUNT(4), .DIV_W(3)) u_div4 (
    .clock(clock), .reset(reset), .load(load), .data_in(data_in), .mode(mode),
    .pause(pause), .stop(stop), .q(q4), .serial_out(so4), .busy(busy4), .done(done4)
  );

  scroll_shift_register #(.WIDTH(8), .DIV_COUNT(1), .DIV_W(1)) u_div1 (
    .clock(clock), .reset(reset), .load(load), .data_in(data_in), .mode(mode),
    .pause(pause), .stop(stop), .q(q1), .serial_out(so1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference of one instance, written from the mode table.
  typedef struct {
    logic [7:0] q;
    logic [1:0] mode;
    int         div;
    int         cnt;
    bit         run;
    bit         done;
  } mdl_t;

  typedef struct {
    logic [7:0] q4;  logic b4, d4, s4;
    logic [7:0] q1;  logic b1, d1, s1;
  } exp_t;

  mdl_t m4, m1;
  exp_t sb[$];

  function automatic mdl_t mdl_next(mdl_t s, int dc);
    mdl_t n = s;
    n.done = 0;
    if (reset) begin
      n.q = 0; n.mode = 0; n.div = 0; n.cnt = 0; n.run = 0;
    end else if (load) begin
      n.q = data_in; n.mode = mode; n.div = 0; n.cnt = 0; n.run = 1;
    end else if (s.run && stop) begin
      n.run = 0;
    end else if (s.run && !pause) begin
      if (s.div == dc - 1) begin
        n.div = 0;
        n.cnt = s.cnt + 1;
        case (s.mode)
          2'd0: n.q = 8'((s.q * 2) % 256);
          2'd1: n.q = 8'(s.q / 2);
          2'd2: n.q = 8'(((s.q * 2) % 256) + s.q / 128);
          default: n.q = 8'(s.q / 2 + (s.q % 2) * 128);
        endcase
        if (s.mode < 2 && n.cnt == 8) begin
          n.run = 0; n.done = 1;
        end
      end else begin
        n.div = s.div + 1;
      end
    end
    return n;
  endfunction

  function automatic logic so_of(mdl_t s);
    return s.mode[0] ? s.q[0] : s.q[7];
  endfunction

  // One clock: push the expected post-edge outputs, then pop and compare
  // against both instances shortly after the edge.
  task automatic cyc();
    exp_t e;
    m4 = mdl_next(m4, 4);
    m1 = mdl_next(m1, 1);
    sb.push_back('{m4.q, m4.run, m4.done, so_of(m4), m1.q, m1.run, m1.done, so_of(m1)});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk("sb_q4", q4, e.q4);     chk("sb_busy4", busy4, e.b4);
    chk("sb_done4", done4, e.d4); chk("sb_so4", so4, e.s4);
    chk("sb_q1", q1, e.q1);     chk("sb_busy1", busy1, e.b1);
    chk("sb_done1", done1, e.d1); chk("sb_so1", so1, e.s1);
    load = 0;
    stop = 0;
  endtask

  task automatic do_load(input logic [7:0] d, input logic [1:0] md);
    data_in = d; mode = md; load = 1;
    cyc();
  endtask

  logic [7:0] sl_tab [9] = '{8'hA5, 8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
  logic       sl_so  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] rr_tab [9] = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81, 8'hC0};

  initial begin
    m4 = '{8'h00, 2'b00, 0, 0, 0, 0};
    m1 = m4;
    // Reset with arbitrary other inputs asserted.
    reset = 1; load = 1; data_in = 8'h5A; mode = 2'b11; pause = 1; stop = 1;
    cyc();
    load = 1; stop = 1;
    cyc();
    reset = 0; pause = 0;
    chk("rst_q", q4, 8'h00); chk("rst_busy", busy4, 1'b0);
    chk("rst_done", done4, 1'b0); chk("rst_so", so4, 1'b0);
    repeat (10) cyc();
    chk("idle_q", q4, 8'h00); chk("idle_busy", busy4, 1'b0);

    // Shift-left A5: step every 4 clocks, done on the 8th step.
    do_load(8'hA5, 2'b00);
    chk("sl_q0", q4, 8'hA5); chk("sl_so0", so4, 1'b1);
    for (int i = 1; i <= 32; i++) begin
      cyc();
      if (i % 4 == 0) begin
        chk("sl_q", q4, sl_tab[i/4]);
        chk("sl_so", so4, sl_so[i/4]);
      end
      chk("sl_done", done4, (i == 32));
      chk("sl_busy", busy4, (i < 32));
    end
    cyc();
    chk("sl_done_gone", done4, 1'b0);

    // Rotate-right 81 runs indefinitely, never done.
    do_load(8'h81, 2'b11);
    for (int i = 1; i <= 36; i++) begin
      cyc();
      if (i % 4 == 0) chk("rr_q", q4, rr_tab[i/4 - 1]);
      chk("rr_done", done4, 1'b0);
      chk("rr_busy", busy4, 1'b1);
    end
    // Restart, stop on the edge that would carry the 4th step.
    do_load(8'h81, 2'b11);
    repeat (12) cyc();
    chk("rr_q3", q4, 8'h30);
    repeat (3) cyc();
    stop = 1;
    cyc();
    chk("stop_q", q4, 8'h30); chk("stop_busy", busy4, 1'b0); chk("stop_done", done4, 1'b0);
    repeat (5) cyc();
    chk("stop_hold", q4, 8'h30);

    // Pause for 10 clocks starting two clocks after load.
    do_load(8'hF0, 2'b01);
    cyc(); cyc();
    pause = 1;
    repeat (10) begin
      cyc();
      chk("ps_busy", busy4, 1'b1);
    end
    pause = 0;
    cyc();
    chk("ps_q13", q4, 8'hF0);
    cyc();
    chk("ps_q14", q4, 8'h78);
    // Load while paused loads but does not step.
    pause = 1;
    do_load(8'h3C, 2'b10);
    chk("pld_q", q4, 8'h3C);
    repeat (5) cyc();
    chk("pld_hold", q4, 8'h3C);
    pause = 0;
    repeat (3) cyc();
    chk("pld_q3", q4, 8'h3C);
    cyc();
    chk("pld_step", q4, 8'h78);

    // Reload mid-run, with stop in the same cycle.
    do_load(8'hA5, 2'b00);
    repeat (8) cyc();
    chk("rl_q94", q4, 8'h94);
    stop = 1;
    do_load(8'h0F, 2'b10);
    chk("rl_q", q4, 8'h0F); chk("rl_busy", busy4, 1'b1);
    repeat (3) cyc();
    chk("rl_q3", q4, 8'h0F);
    cyc();
    chk("rl_step", q4, 8'h1E);
    stop = 1;
    cyc();
    chk("rl_stop", busy4, 1'b0);

    // Reset mid-run.
    do_load(8'hA5, 2'b00);
    repeat (12) cyc();
    chk("rr_pre_q", q4, 8'h28); chk("rr_pre_busy", busy4, 1'b1);
    reset = 1;
    cyc();
    reset = 0;
    chk("mrst_q", q4, 8'h00); chk("mrst_busy", busy4, 1'b0);

    // DIV_COUNT=1: one step per clock, done after exactly 8 clocks.
    do_load(8'hA5, 2'b00);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i == 1) chk("d1_q1", q1, 8'h4A);
      chk("d1_done", done1, (i == 8));
      chk("d1_busy", busy1, (i < 8));
    end
    chk("d1_qend", q1, 8'h00);
    cyc();
    chk("d1_done_gone", done1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/scroll_shift_register.md
Name: scroll_shift_register

Overview:
Parametrised, loadable scroll/shift engine for the display and LED-scroll paths. Holds a WIDTH-bit pattern and steps it at a programmable rate set by an internal rate divider, so no external slow clock is needed. Supports four modes: shift left, shift right, rotate left and rotate right. Also provides pause, stop, busy and completion signalling. Successor to the fixed 12-bit left-only shifter paired with a separate divider.

Parameters:
WIDTH, 12, pattern width in bits (≥2)
DIV_COUNT, 1000000, clock cycles per step (≥1)
DIV_W, 27, divider counter width; must hold DIV_COUNT-1

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high; highest priority
load  in  1  single-cycle pulse: capture data_in and mode, start run
data_in  in  WIDTH  pattern to load
mode  in  2  00 shift-left zero-fill, 01 shift-right zero-fill, 10 rotate-left, 11 rotate-right
pause  in  1  level; while high, divider and pattern frozen
stop  in  1  single-cycle pulse: abort run, return to IDLE
q  out  WIDTH  current pattern
serial_out  out  1  q[WIDTH-1] in modes 00/10; q[0] in modes 01/11 (combinational from q and latched mode)
busy  out  1  high in RUN
done  out  1  one-cycle pulse on natural completion of a shift mode

Behaviour:
- Reset (sync, sampled on posedge):
  - q=0, latched mode=00, divider=0, step counter=0.
  - state=IDLE, busy=0, done=0.
  - Reset overrides every other input in the same cycle.
- States:
  - IDLE: q holds its value; divider and step counter hold.
  - RUN: busy=1.
- Load (any state, reset low):
  - q←data_in, mode latched, divider←0, step counter←0, state←RUN, done←0.
  - Load overrides stop and any step in the same cycle.
  - Load mid-run restarts cleanly.
- Stop (RUN, no load): state←IDLE, q frozen at current value, no done pulse. Stop in IDLE has no effect.
- Divider (RUN, pause=0):
  - If divider==DIV_COUNT-1: step, divider←0. Else divider←divider+1.
  - Load on edge k gives steps on edges k+DIV_COUNT, k+2·DIV_COUNT, …
  - DIV_COUNT=1 steps every cycle.
- Pause=1 in RUN: divider and q hold; busy stays 1; counting resumes from the held divider value. Load while paused still loads but does not step until pause drops.
- Step operations:
  - 00: q←{q[WIDTH-2:0],0}
  - 01: q←{0,q[WIDTH-1:1]}
  - 10: q←{q[WIDTH-2:0],q[WIDTH-1]}
  - 11: q←{q[0],q[WIDTH-1:1]}
- Shift modes (00/01):
  - Step counter increments per step.
  - On the WIDTH-th step: q becomes 0, state←IDLE, done=1 for exactly that cycle (registered, coincident with final q update).
  - Counter width ≥ clog2(WIDTH+1).
- Rotate modes (10/11): run indefinitely until stop, load or reset; step counter wraps without side effects; done never asserts.
- Simultaneous stop and step edge: stop wins, no step applied.
- done is 0 in every cycle other than the completion cycle.

Test Plan:
- Reset: reset=1 for 2 cycles with arbitrary inputs → q=0, busy=0, done=0, serial_out=0. Then load=0 for 10 cycles → outputs unchanged.
- Shift-left, WIDTH=8, DIV_COUNT=4, load 8'hA5 mode 00 at edge k:
  - q=A5 after k, then 4A,94,28,50,A0,40,80,00 at edges k+4…k+32.
  - serial_out sequence 1,0,1,0,0,1,0,1,0.
  - done=1 only in the cycle after edge k+32; busy falls at the same edge.
- Rotate-right, load 8'h81 mode 11 → q=C0,60,30,18,0C,06,03,81,C0… with no done. Stop pulse after the 3rd step → q frozen at 30, busy=0.
- Pause: mode 01 load 8'hF0, pause=1 for 10 cycles starting 2 cycles after load → first step (q=78) delayed by exactly 10 cycles, i.e. at edge k+14.
- Reload mid-run: mode 00 running at q=94, load 8'h0F mode 10 → q=0F immediately, next step at +4 cycles gives 1E, step counter restarted. Load and stop in the same cycle → load wins.
- Reset mid-run: reset asserted while RUN with q=28 → next edge q=0, busy=0. Also run DIV_COUNT=1 variant → one step per cycle, done after exactly WIDTH cycles.
